// File: rtl/result_uart_tx.sv
// UART transmitter that reports a BCD classification result as "<digit>\r\n".
// Each message is three 8N1/8N2 frames; tx, busy and done all come straight from flops.
module result_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] answer,
    input  logic       answer_valid,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic             stop_idx_q, stop_idx_d;
    logic [3:0]       ans_q, ans_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [7:0] cur_byte;
    logic [2:0] nxt_bit;
    logic       baud_end;

    // Byte currently being framed, selected by message position.
    always_comb begin
        cur_byte = 8'h0A;
        case (byte_idx_q)
            2'd0:    cur_byte = (ans_q <= 4'd9) ? (8'h30 + 8'(ans_q)) : 8'h3F;
            2'd1:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    assign nxt_bit  = bit_idx_q + 3'd1;
    assign baud_end = (baud_q == BAUD_LAST);

    // Next-state and registered-output logic; tx_d is the level for the following cycle.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        stop_idx_d = stop_idx_q;
        ans_d      = ans_q;
        tx_d       = tx_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (answer_valid) begin
                    ans_d      = answer;
                    state_d    = S_START;
                    tx_d       = 1'b0;
                    baud_d     = '0;
                    byte_idx_d = 2'd0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d    = '0;
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = cur_byte[0];
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d    = S_STOP;
                        stop_idx_d = 1'b0;
                        tx_d       = 1'b1;
                    end else begin
                        bit_idx_d = nxt_bit;
                        tx_d      = cur_byte[nxt_bit];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (baud_end) begin
                    baud_d = '0;
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = S_NEXT;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_NEXT: begin
                if (byte_idx_q < 2'd2) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    state_d    = S_START;
                    tx_d       = 1'b0;
                    baud_d     = '0;
                end else begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 2'd0;
            stop_idx_q <= 1'b0;
            ans_q      <= 4'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            stop_idx_q <= stop_idx_d;
            ans_q      <= ans_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: a mid-bit UART sampler checks frames against a byte queue.
module tb_result_uart_tx;

    localparam int unsigned CA = 4;
    localparam int unsigned SA = 1;
    localparam int unsigned CB = 217;
    localparam int unsigned SB = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] answer_a, answer_b;
    logic       valid_a, valid_b;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;

    int         cyc = 0;
    int         vec = 0;
    int         errs = 0;
    int         done_cnt_a = 0;
    logic [7:0] exp_q[$];

    result_uart_tx #(.CLKS_PER_BIT(CA), .STOP_BITS(SA)) u_a (
        .clk(clk), .rst(rst), .answer(answer_a), .answer_valid(valid_a),
        .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    result_uart_tx #(.CLKS_PER_BIT(CB), .STOP_BITS(SB)) u_b (
        .clk(clk), .rst(rst), .answer(answer_b), .answer_valid(valid_b),
        .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic txs(input int sel);
        return sel ? tx_b : tx_a;
    endfunction

    function automatic logic busys(input int sel);
        return sel ? busy_b : busy_a;
    endfunction

    function automatic logic dones(input int sel);
        return sel ? done_b : done_a;
    endfunction

    function automatic logic [7:0] digit(input logic [3:0] a);
        return (a <= 4'd9) ? (8'h30 + {4'h0, a}) : 8'h3F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Pulse a one-cycle request and queue the expected message.
    task automatic send(input int sel, input logic [3:0] a);
        @(negedge clk);
        if (sel != 0) begin answer_b = a; valid_b = 1'b1; end
        else          begin answer_a = a; valid_a = 1'b1; end
        exp_q.push_back(digit(a));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
        chk("latency_tx_low", 32'(txs(sel)), 32'd0);
        chk("busy_after_accept", 32'(busys(sel)), 32'd1);
    endtask

    task automatic recv_byte(input int sel, input int c, input int s,
                             output logic [7:0] b, output int t_start);
        int n = 0;
        while (txs(sel) !== 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("rx_start_timeout", 32'(n < 20000), 32'd1);
        t_start = cyc;
        repeat (c / 2) @(negedge clk);
        chk("rx_start_bit", 32'(txs(sel)), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (c) @(negedge clk);
            b[i] = txs(sel);
        end
        for (int k = 0; k < s; k++) begin
            repeat (c) @(negedge clk);
            chk("rx_stop_bit", 32'(txs(sel)), 32'd1);
        end
    endtask

    task automatic recv_msg(input int sel, input int c, input int s, output int t0);
        logic [7:0] b;
        int         ts;
        t0 = cyc;
        for (int j = 0; j < 3; j++) begin
            recv_byte(sel, c, s, b, ts);
            if (j == 0) t0 = ts;
            if (exp_q.size() == 0) begin
                chk("rx_unexpected_byte", 32'(b), 32'hFFFF);
            end else begin
                chk("rx_byte", 32'(b), 32'(exp_q.pop_front()));
            end
        end
    endtask

    // Wait for done, check message duration and busy handoff; optionally chain a request.
    task automatic wait_done(input int sel, input int t0, input int dur,
                             input bit chain, input logic [3:0] a);
        int   n = 0;
        logic prev_busy = busys(sel);
        while (dones(sel) !== 1'b1 && n < 20000) begin
            prev_busy = busys(sel);
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(n < 20000), 32'd1);
        chk("done_latency", 32'(cyc - t0), 32'(dur));
        chk("busy_before_done", 32'(prev_busy), 32'd1);
        chk("busy_in_done", 32'(busys(sel)), 32'd0);
        if (chain) begin
            answer_a = a;
            valid_a  = 1'b1;
            exp_q.push_back(digit(a));
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
        @(negedge clk);
        valid_a = 1'b0;
        chk("done_one_cycle", 32'(dones(sel)), 32'd0);
        if (chain) begin
            chk("chain_tx_low", 32'(txs(sel)), 32'd0);
            chk("chain_busy", 32'(busys(sel)), 32'd1);
        end
    endtask

    localparam int DUR_A = 3 * (9 + SA) * CA + 3;
    localparam int DUR_B = 3 * (9 + SB) * CB + 3;

    initial begin
        int t0;
        int dc;
        rst      = 1'b1;
        answer_a = 4'd0;
        answer_b = 4'd0;
        valid_a  = 1'b0;
        valid_b  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx_a), 32'd1);
        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_done", 32'(done_a), 32'd0);
        chk("reset_tx_b", 32'(tx_b), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // answer 7: full message and exact timing
        send(0, 4'd7);
        recv_msg(0, CA, SA, t0);
        wait_done(0, t0, DUR_A, 1'b0, 4'd0);
        chk("done_count_1", 32'(done_cnt_a), 32'd1);

        // out-of-range answer and zero
        send(0, 4'd12);
        recv_msg(0, CA, SA, t0);
        wait_done(0, t0, DUR_A, 1'b0, 4'd0);
        send(0, 4'd0);
        recv_msg(0, CA, SA, t0);
        wait_done(0, t0, DUR_A, 1'b0, 4'd0);

        // request while busy is ignored
        send(0, 4'd9);
        fork
            recv_msg(0, CA, SA, t0);
            begin
                repeat (20) @(negedge clk);
                answer_a = 4'd3;
                valid_a  = 1'b1;
                @(negedge clk);
                valid_a = 1'b0;
                chk("busy_ignore", 32'(busy_a), 32'd1);
            end
        join
        wait_done(0, t0, DUR_A, 1'b0, 4'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // reset during data bit 4 of byte 1, with a request held during reset
        send(0, 4'd7);
        t0 = cyc;
        dc = done_cnt_a;
        repeat (62) @(negedge clk);
        chk("mid_byte1_bit4", 32'(tx_a), 32'd0);
        rst      = 1'b1;
        answer_a = 4'd9;
        valid_a  = 1'b1;
        @(negedge clk);
        chk("rst_tx", 32'(tx_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        valid_a = 1'b0;
        @(negedge clk);
        chk("rst_valid_ignored", 32'(busy_a), 32'd0);
        repeat (10) @(negedge clk);
        chk("rst_no_residual_tx", 32'(tx_a), 32'd1);
        chk("rst_no_done", 32'(done_cnt_a), 32'(dc));
        exp_q.delete();
        send(0, 4'd4);
        recv_msg(0, CA, SA, t0);
        wait_done(0, t0, DUR_A, 1'b1, 4'd6);

        // back-to-back: request in done cycle, then receive the chained message
        recv_msg(0, CA, SA, t0);
        wait_done(0, t0, DUR_A, 1'b0, 4'd0);
        chk("queue_empty_a", 32'(exp_q.size()), 32'd0);

        // two stop bits at 217 clocks per bit
        send(1, 4'd5);
        recv_msg(1, CB, SB, t0);
        wait_done(1, t0, DUR_B, 1'b0, 4'd0);
        chk("queue_empty_b", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
